// File: rtl/i2c_cmd_arb.sv
// ============================================================================
// Module      : i2c_cmd_arb
// Description : Two-requester round-robin arbiter in front of an I2C byte
//               engine. Requester 0 carries command/init traffic, requester 1
//               carries display data. A granted byte is latched, handed to the
//               engine with a control byte (0x00 command / 0x40 data), and the
//               outcome is reported back as a done/err pulse pair.
// Revision    : 1.0 - initial release
//
// Ports
//   clk2                  in   sole clock, rising edge
//   reset                 in   asynchronous active-low reset
//   req0/req1             in   transfer request per requester
//   dc0/dc1               in   0 = command byte, 1 = display data byte
//   byte0/byte1     [7:0] in   payload byte per requester
//   gnt0/gnt1             out  one-cycle grant pulse (payload sampled)
//   done0/done1           out  one-cycle completion pulse
//   err0/err1             out  valid with done: NACK exhausted or timeout
//   eng_start             out  one-cycle start to the byte engine
//   eng_ctrl        [7:0] out  control byte for the engine
//   eng_data        [7:0] out  latched payload byte
//   eng_busy              in   engine busy level
//   eng_done              in   engine completion pulse
//   eng_nack              in   engine NACK flag, valid with eng_done
//   busy                  out  high whenever the arbiter is not idle
//
// Configuration
//   I2C_ARB_RETRY_EN  when defined, a NACKed byte is re-issued up to
//                     RETRY_MAX times before reporting an error; when
//                     undefined, any NACK is reported as an error at once and
//                     no retry counter exists.
// ============================================================================
`default_nettype none

module i2c_cmd_arb #(
    parameter int RETRY_MAX = 2,
    parameter int TIMEOUT   = 1023
) (
    input  logic       clk2,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       dc0,
    input  logic       dc1,
    input  logic [7:0] byte0,
    input  logic [7:0] byte1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic       err0,
    output logic       err1,
    output logic       eng_start,
    output logic [7:0] eng_ctrl,
    output logic [7:0] eng_data,
    input  logic       eng_busy,
    input  logic       eng_done,
    input  logic       eng_nack,
    output logic       busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Last counter value seen in WAIT before the timeout fires, so that DONE
    // is entered exactly TIMEOUT cycles after WAIT entry.
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

    logic [1:0] state;
    logic       last_grant;   // requester served by the previous transfer
    logic       cur;          // requester owning the current transfer
    logic [9:0] to_cnt;

    logic       pick1;
    logic       can_retry;
    logic       fin_ok;
    logic       fin_err;

    // Requester 1 wins when it is alone, or on a tie when requester 0 was
    // served last.
    assign pick1 = req1 & (~req0 | ~last_grant);

`ifdef I2C_ARB_RETRY_EN
    localparam int         RW        = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);

    logic [RW-1:0] retry_cnt;

    assign can_retry = (retry_cnt < RETRY_LIM);

    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            retry_cnt <= '0;
        end else if (state == S_IDLE && (req0 || req1)) begin
            retry_cnt <= '0;
        end else if (state == S_WAIT && eng_done && eng_nack && can_retry) begin
            retry_cnt <= retry_cnt + 1'b1;
        end
    end
`else
    assign can_retry = 1'b0;
`endif

    // Outcomes that close the transfer while in WAIT.
    assign fin_ok  = eng_done & ~eng_nack;
    assign fin_err = (eng_done & eng_nack & ~can_retry) |
                     (~eng_done & (to_cnt == TO_LAST));

    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            cur        <= 1'b0;
            to_cnt     <= '0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            eng_start  <= 1'b0;
            eng_ctrl   <= 8'h00;
            eng_data   <= 8'h00;
            busy       <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            eng_start <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        cur      <= pick1;
                        gnt0     <= ~pick1;
                        gnt1     <= pick1;
                        eng_ctrl <= (pick1 ? dc1 : dc0) ? 8'h40 : 8'h00;
                        eng_data <= pick1 ? byte1 : byte0;
                        busy     <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    // Engine outcome inputs are not looked at here.
                    if (!eng_busy) begin
                        eng_start <= 1'b1;
                        to_cnt    <= '0;
                        state     <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (fin_ok || fin_err) begin
                        done0 <= ~cur;
                        done1 <= cur;
                        err0  <= ~cur & fin_err;
                        err1  <= cur & fin_err;
                        state <= S_DONE;
                    end else if (eng_done) begin
                        // NACK with retries left: re-issue the same byte.
                        state <= S_ISSUE;
                    end else begin
                        to_cnt <= to_cnt + 10'd1;
                    end
                end

                default: begin
                    last_grant <= cur;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2c_cmd_arb.sv
`default_nettype none

module tb_i2c_cmd_arb;

    logic       clk2 = 1'b0;
    logic       reset;
    logic       req0, req1, dc0, dc1;
    logic [7:0] byte0, byte1;
    logic       gnt0, gnt1, done0, done1, err0, err1;
    logic       eng_start;
    logic [7:0] eng_ctrl, eng_data;
    logic       eng_busy, eng_done, eng_nack;
    logic       busy;

    int total = 0;
    int bad   = 0;

    i2c_cmd_arb #(.RETRY_MAX(2), .TIMEOUT(1023)) dut (
        .clk2      (clk2),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .dc0       (dc0),
        .dc1       (dc1),
        .byte0     (byte0),
        .byte1     (byte1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .done0     (done0),
        .done1     (done1),
        .err0      (err0),
        .err1      (err1),
        .eng_start (eng_start),
        .eng_ctrl  (eng_ctrl),
        .eng_data  (eng_data),
        .eng_busy  (eng_busy),
        .eng_done  (eng_done),
        .eng_nack  (eng_nack),
        .busy      (busy)
    );

    always #5 clk2 = ~clk2;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk2);
        #1;
    endtask

    // One transfer: wait for the grant, act as an engine that NACKs the
    // first 'nacks' starts and ACKs afterwards, then check the outcome.
    task automatic run_xfer(input logic who, input logic [7:0] ctrl,
                            input logic [7:0] data, input int nacks,
                            input logic err, input int starts,
                            input logic drop);
        bit seen;
        int n_start;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (gnt0 || gnt1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("xfer_gnt_seen", seen, 1'b1);
        chk("xfer_gnt_who", gnt1, who);
        if (drop) begin
            req0 = 1'b0;
            req1 = 1'b0;
        end
        n_start = 0;
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (done0 || done1) begin
                seen = 1'b1;
                break;
            end
            if (eng_start) begin
                n_start++;
                chk("xfer_ctrl", eng_ctrl, ctrl);
                chk("xfer_data", eng_data, data);
                eng_done = 1'b1;
                eng_nack = (n_start <= nacks);
            end else begin
                eng_done = 1'b0;
                eng_nack = 1'b0;
            end
        end
        eng_done = 1'b0;
        eng_nack = 1'b0;
        chk("xfer_done_seen", seen, 1'b1);
        chk("xfer_done_who", done1, who);
        chk("xfer_err", who ? err1 : err0, err);
        chk("xfer_starts", n_start, starts);
    endtask

    initial begin
        int  n;
        bit  g;
        reset    = 1'b0;
        req0     = 1'b0;
        req1     = 1'b0;
        dc0      = 1'b0;
        dc1      = 1'b0;
        byte0    = 8'h00;
        byte1    = 8'h00;
        eng_busy = 1'b0;
        eng_done = 1'b0;
        eng_nack = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_gnt", {gnt0, gnt1}, 2'b00);
        chk("rst_done", {done0, done1, err0, err1}, 4'h0);
        chk("rst_start", eng_start, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ctrl", eng_ctrl, 8'h00);
        chk("rst_data", eng_data, 8'h00);
        reset = 1'b1;

        // Single command byte, engine acks about 20 cycles later
        req0  = 1'b1;
        dc0   = 1'b0;
        byte0 = 8'hAE;
        tick();
        chk("s_gnt0", gnt0, 1'b1);
        chk("s_gnt1", gnt1, 1'b0);
        chk("s_busy", busy, 1'b1);
        chk("s_nostart", eng_start, 1'b0);
        req0 = 1'b0;
        tick();
        chk("s_start", eng_start, 1'b1);
        chk("s_gnt_pulse", gnt0, 1'b0);
        chk("s_ctrl", eng_ctrl, 8'h00);
        chk("s_data", eng_data, 8'hAE);
        tick();
        chk("s_start_pulse", eng_start, 1'b0);
        repeat (18) tick();
        chk("s_no_early_done", done0, 1'b0);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        chk("s_done0", done0, 1'b1);
        chk("s_err0", err0, 1'b0);
        chk("s_done1", done1, 1'b0);
        chk("s_data_hold", eng_data, 8'hAE);
        tick();
        chk("s_done_pulse", done0, 1'b0);
        chk("s_idle_busy", busy, 1'b0);

        // Round robin after a fresh reset, both requesters held
        reset = 1'b0;
        tick();
        reset = 1'b1;
        req0  = 1'b1;
        req1  = 1'b1;
        dc0   = 1'b0;
        byte0 = 8'h11;
        dc1   = 1'b1;
        byte1 = 8'h5A;
        run_xfer(1'b0, 8'h00, 8'h11, 0, 1'b0, 1, 1'b0);
        run_xfer(1'b1, 8'h40, 8'h5A, 0, 1'b0, 1, 1'b0);
        run_xfer(1'b0, 8'h00, 8'h11, 0, 1'b0, 1, 1'b0);
        run_xfer(1'b1, 8'h40, 8'h5A, 0, 1'b0, 1, 1'b1);

`ifdef I2C_ARB_RETRY_EN
        // Three NACKs exhaust two retries; two NACKs then ACK succeeds
        req1  = 1'b1;
        dc1   = 1'b0;
        byte1 = 8'h77;
        run_xfer(1'b1, 8'h00, 8'h77, 3, 1'b1, 3, 1'b1);
        req1 = 1'b1;
        run_xfer(1'b1, 8'h00, 8'h77, 2, 1'b0, 3, 1'b1);
`else
        // Single NACK is reported immediately
        req0  = 1'b1;
        dc0   = 1'b1;
        byte0 = 8'h3C;
        run_xfer(1'b0, 8'h40, 8'h3C, 1, 1'b1, 1, 1'b1);
`endif
        tick();

        // Timeout: engine never answers; a short req1 pulse is not served
        req0 = 1'b1;
        tick();
        chk("to_gnt0", gnt0, 1'b1);
        req0 = 1'b0;
        tick();
        chk("to_start", eng_start, 1'b1);
        n = 0;
        for (int c = 0; c < 1100; c++) begin
            req1 = (n == 5);
            tick();
            n++;
            if (done0) break;
        end
        req1 = 1'b0;
        chk("to_cycles", n, 1023);
        chk("to_done0", done0, 1'b1);
        chk("to_err0", err0, 1'b1);
        tick();
        chk("to_busy_after", busy, 1'b0);
        g = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            g = g | gnt1;
        end
        chk("drop_not_served", g, 1'b0);

        // Engine busy delays the start; engine strobes before WAIT ignored
        req1     = 1'b1;
        dc1      = 1'b1;
        byte1    = 8'hC3;
        eng_busy = 1'b1;
        eng_done = 1'b1;
        eng_nack = 1'b1;
        tick();
        chk("eb_gnt1", gnt1, 1'b1);
        req1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("eb_start_held", eng_start, 1'b0);
        end
        chk("eb_no_done", done1, 1'b0);
        chk("eb_busy", busy, 1'b1);
        eng_busy = 1'b0;
        eng_done = 1'b0;
        eng_nack = 1'b0;
        tick();
        chk("eb_start", eng_start, 1'b1);
        chk("eb_ctrl", eng_ctrl, 8'h40);
        chk("eb_data", eng_data, 8'hC3);
        tick();
        tick();

        // Reset in WAIT aborts silently
        reset = 1'b0;
        #1;
        chk("ra_busy", busy, 1'b0);
        chk("ra_ctrl", eng_ctrl, 8'h00);
        chk("ra_data", eng_data, 8'h00);
        chk("ra_start", eng_start, 1'b0);
        tick();
        tick();
        chk("ra_no_done", {done0, done1, err0, err1}, 4'h0);
        reset = 1'b1;
        req0  = 1'b1;
        tick();
        chk("ra_first_gnt", gnt0, 1'b1);
        req0 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
